// File: rtl/mult_datapath_if.sv
// Control/data bundle between mult_control, the operand source and mult_datapath.
// master drives operands and control strobes; slave is the datapath.
interface mult_datapath_if #(
  parameter int DATA_W = 8
);
  localparam int ACC_W = 2 * DATA_W;

  logic              start;
  logic [DATA_W-1:0] dataa;
  logic [DATA_W-1:0] datab;
  logic [1:0]        input_sel;
  logic [1:0]        shift_sel;
  logic              clk_ena;
  logic              sclr_n;
  logic              done;
  logic [1:0]        count;
  logic [ACC_W-1:0]  product;
  logic [ACC_W-1:0]  result;
  logic              result_valid;

  modport master (
    output start, dataa, datab, input_sel, shift_sel, clk_ena, sclr_n, done,
    input  count, product, result, result_valid
  );

  modport slave (
    input  start, dataa, datab, input_sel, shift_sel, clk_ena, sclr_n, done,
    output count, product, result, result_valid
  );
endinterface

// File: rtl/mult_datapath.sv
// Nibble-serial 8x8 multiplier datapath: selects, shifts and accumulates one
// 4x4 partial product per cycle under mult_control, then captures the result.
module mult_datapath #(
  parameter int DATA_W = 8,
  parameter int NIB_W  = DATA_W / 2,
  parameter int ACC_W  = 2 * DATA_W
) (
  input  logic           clk,
  input  logic           reset_a,
  mult_datapath_if.slave dp
);
  localparam int PP_W = 2 * NIB_W;

  generate
    if (DATA_W != 8 || NIB_W != DATA_W / 2 || ACC_W != 2 * DATA_W) begin : g_bad_param
      $error("mult_datapath supports only DATA_W=8, NIB_W=4, ACC_W=16");
    end
  endgenerate

  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [1:0]        count_q, count_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic              done_dly_q;
  logic              result_valid_q, result_valid_d;

  logic [NIB_W-1:0]  na, nb;
  logic [PP_W-1:0]   pp;
  logic [ACC_W-1:0]  shifted;
  logic              done_rise;

  function automatic logic [PP_W-1:0] nib_mul(input logic [NIB_W-1:0] a,
                                              input logic [NIB_W-1:0] b);
    logic [PP_W-1:0] p;
    p = PP_W'(a) * PP_W'(b);
    return p;
  endfunction

  // Unused select code 11 deliberately maps to no shift so it never yields X.
  function automatic logic [ACC_W-1:0] shift_pp(input logic [PP_W-1:0] p,
                                                input logic [1:0]      sel);
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] res;
    ext = ACC_W'(p);
    case (sel)
      2'b01:   res = ext << NIB_W;
      2'b10:   res = ext << (2 * NIB_W);
      default: res = ext;
    endcase
    return res;
  endfunction

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] s;
    s = a + b;
    return s;
  endfunction

  always_comb begin
    na      = dp.input_sel[1] ? opa_q[DATA_W-1:NIB_W] : opa_q[NIB_W-1:0];
    nb      = dp.input_sel[0] ? opb_q[DATA_W-1:NIB_W] : opb_q[NIB_W-1:0];
    pp      = nib_mul(na, nb);
    shifted = shift_pp(pp, dp.shift_sel);
  end

  assign done_rise = dp.done & ~done_dly_q;

  always_comb begin
    opa_d          = opa_q;
    opb_d          = opb_q;
    count_d        = count_q + 2'd1;
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = 1'b0;

    if (dp.start) begin
      opa_d   = dp.dataa;
      opb_d   = dp.datab;
      count_d = 2'd0;
    end

    if (dp.clk_ena) begin
      acc_d = dp.sclr_n ? acc_add(acc_q, shifted) : shifted;
    end

    // Capture uses the accumulator as it stands before this edge.
    if (done_rise) begin
      result_d       = acc_q;
      result_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_a) begin
      opa_q          <= '0;
      opb_q          <= '0;
      count_q        <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      done_dly_q     <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      count_q        <= count_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      done_dly_q     <= dp.done;
      result_valid_q <= result_valid_d;
    end
  end

  assign dp.count        = count_q;
  assign dp.product      = acc_q;
  assign dp.result       = result_q;
  assign dp.result_valid = result_valid_q;

endmodule

// File: tb/tb_mult_datapath.sv
// Bench for mult_datapath: directed scenarios plus random control traffic,
// compared against an arithmetic reference model of the multiplier datapath.
module tb_mult_datapath;
  logic clk = 1'b0;
  logic reset_a;

  mult_datapath_if bus ();

  mult_datapath dut (
    .clk     (clk),
    .reset_a (reset_a),
    .dp      (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_a, m_b, m_acc, m_cnt, m_res, m_vld, m_done_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int term(input int a, input int b, input logic [1:0] sel,
                              input logic [1:0] sh);
    int na, nb, w;
    na = sel[1] ? a / 16 : a % 16;
    nb = sel[0] ? b / 16 : b % 16;
    w  = (sh == 2'b01) ? 16 : (sh == 2'b10) ? 256 : 1;
    return na * nb * w;
  endfunction

  task automatic tick();
    if (reset_a) begin
      m_a = 0; m_b = 0; m_acc = 0; m_cnt = 0; m_res = 0; m_vld = 0; m_done_prev = 0;
    end else begin
      m_vld = (bus.done && !m_done_prev) ? 1 : 0;
      if (m_vld == 1) m_res = m_acc;
      m_done_prev = bus.done ? 1 : 0;
      if (bus.clk_ena)
        m_acc = ((bus.sclr_n ? m_acc : 0) + term(m_a, m_b, bus.input_sel, bus.shift_sel)) % 65536;
      m_cnt = bus.start ? 0 : (m_cnt + 1) % 4;
      if (bus.start) begin
        m_a = int'(bus.dataa);
        m_b = int'(bus.datab);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_count"},   32'(bus.count),        32'(m_cnt));
    check({tag, "_product"}, 32'(bus.product),      32'(m_acc));
    check({tag, "_result"},  32'(bus.result),       32'(m_res));
    check({tag, "_valid"},   32'(bus.result_valid), 32'(m_vld));
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    bus.start = 1'b1; bus.dataa = a; bus.datab = b; bus.clk_ena = 1'b0; bus.done = 1'b0;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic seq_step(input int k);
    logic [1:0] sh_tab [4];
    sh_tab = '{2'b00, 2'b01, 2'b01, 2'b10};
    bus.input_sel = 2'(k);
    bus.shift_sel = sh_tab[k];
    bus.sclr_n    = (k != 0);
    bus.clk_ena   = 1'b1;
    tick();
    check_all("step");
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ff_exp [4];
    ff_exp = '{16'h00E1, 16'h0EF1, 16'h1D01, 16'hFE01};
    load(a, b);
    for (int k = 0; k < 4; k++) begin
      seq_step(k);
      if (a == 8'hFF && b == 8'hFF) check("ff_step", 32'(bus.product), 32'(ff_exp[k]));
    end
    bus.clk_ena = 1'b0;
    bus.done = 1'b1;
    tick();
    check("op_result", 32'(bus.result), 32'(int'(a) * int'(b)));
    check("op_valid", 32'(bus.result_valid), 32'd1);
    bus.done = 1'b0;
    tick();
    check("op_valid_drop", 32'(bus.result_valid), 32'd0);
  endtask

  initial begin
    int pulses;

    // Reset with busy, nonzero inputs
    reset_a = 1'b1;
    bus.start = 1'b1; bus.dataa = 8'hFF; bus.datab = 8'hFF;
    bus.input_sel = 2'b11; bus.shift_sel = 2'b10;
    bus.clk_ena = 1'b1; bus.sclr_n = 1'b1; bus.done = 1'b1;
    tick();
    tick();
    check("rst_count",   32'(bus.count),        32'd0);
    check("rst_product", 32'(bus.product),      32'd0);
    check("rst_result",  32'(bus.result),       32'd0);
    check("rst_valid",   32'(bus.result_valid), 32'd0);
    reset_a = 1'b0;
    bus.start = 1'b0; bus.dataa = '0; bus.datab = '0;
    bus.input_sel = '0; bus.shift_sel = '0;
    bus.clk_ena = 1'b0; bus.sclr_n = 1'b0; bus.done = 1'b0;

    // Counter sequence and restart
    bus.start = 1'b1;
    tick();
    check("cnt_start", 32'(bus.count), 32'd0);
    bus.start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("cnt_seq", 32'(bus.count), 32'(i % 4));
    end
    tick();
    check("cnt_two", 32'(bus.count), 32'd2);
    bus.start = 1'b1;
    tick();
    check("cnt_restart", 32'(bus.count), 32'd0);
    bus.start = 1'b0;

    // Directed products
    run_op(8'hFF, 8'hFF);
    check("ff_result", 32'(bus.result), 32'h0000FE01);
    run_op(8'h00, 8'hA5);
    check("zero_result", 32'(bus.result), 32'h00000000);
    run_op(8'h01, 8'h01);
    check("one_result", 32'(bus.result), 32'h00000001);

    // Unused shift code, then hold with clk_ena low
    load(8'hFF, 8'hFF);
    bus.input_sel = 2'b11; bus.shift_sel = 2'b11; bus.sclr_n = 1'b0; bus.clk_ena = 1'b1;
    tick();
    check("shift11", 32'(bus.product), 32'h000000E1);
    bus.clk_ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.input_sel = 2'($urandom_range(0, 3));
      bus.shift_sel = 2'($urandom_range(0, 3));
      bus.sclr_n    = 1'($urandom_range(0, 1));
      tick();
      check("hold", 32'(bus.product), 32'h000000E1);
    end

    // done held high yields a single pulse
    pulses = 0;
    bus.done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.result_valid) pulses++;
      check_all("done_hold");
    end
    check("one_pulse", 32'(pulses), 32'd1);
    bus.done = 1'b0;
    tick();

    // Restart mid-operation with new operands
    load(8'hFF, 8'hFF);
    seq_step(0);
    seq_step(1);
    run_op(8'h12, 8'h34);
    check("restart_result", 32'(bus.result), 32'h000003A8);

    // done rising together with start
    load(8'h05, 8'h07);
    for (int k = 0; k < 4; k++) seq_step(k);
    bus.clk_ena = 1'b0; bus.done = 1'b1;
    bus.start = 1'b1; bus.dataa = 8'h09; bus.datab = 8'h09;
    tick();
    check("coinc_result", 32'(bus.result), 32'd35);
    check("coinc_valid", 32'(bus.result_valid), 32'd1);
    check("coinc_count", 32'(bus.count), 32'd0);
    bus.start = 1'b0; bus.done = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) seq_step(k);
    bus.clk_ena = 1'b0; bus.done = 1'b1;
    tick();
    check("coinc_recapture", 32'(bus.result), 32'd81);
    bus.done = 1'b0;
    tick();

    // Reset mid-accumulation
    load(8'hFF, 8'hFF);
    seq_step(0);
    seq_step(1);
    reset_a = 1'b1;
    tick();
    check("mid_rst_count",   32'(bus.count),        32'd0);
    check("mid_rst_product", 32'(bus.product),      32'd0);
    check("mid_rst_result",  32'(bus.result),       32'd0);
    check("mid_rst_valid",   32'(bus.result_valid), 32'd0);
    reset_a = 1'b0;

    // Random control traffic
    for (int i = 0; i < 300; i++) begin
      bus.start     = ($urandom_range(0, 7) == 0);
      bus.dataa     = 8'($urandom);
      bus.datab     = 8'($urandom);
      bus.input_sel = 2'($urandom_range(0, 3));
      bus.shift_sel = 2'($urandom_range(0, 3));
      bus.clk_ena   = 1'($urandom_range(0, 1));
      bus.sclr_n    = 1'($urandom_range(0, 1));
      bus.done      = ($urandom_range(0, 3) == 0);
      tick();
      check_all("rand");
    end
    bus.done = 1'b0;
    tick();

    // Random full multiplications
    for (int i = 0; i < 10; i++) begin
      run_op(8'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
